// File: rtl/moving_average_pkg.sv
// Shared types and helpers for the moving-average sequencing controller.
package moving_average_pkg;

    typedef enum logic [1:0] {CLEAR, WARMUP, RUN, HOLD} state_t;

    localparam logic [1:0] SEL_W2      = 2'b00;
    localparam logic [1:0] SEL_W4      = 2'b01;
    localparam logic [1:0] SEL_W8      = 2'b10;
    localparam logic [1:0] SEL_INVALID = 2'b11;

    // Window length in samples for a select code: 2^(sel+1).
    function automatic int unsigned win_len(input logic [1:0] sel);
        return 32'd1 << (int'(sel) + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (inc && !(&cnt))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/moving_average_ctrl.sv
// Sequences window changes for the moving-average filter bank: flushes on every
// change, hides warm-up outputs and counts samples dropped during reconfiguration.
module moving_average_ctrl
    import moving_average_pkg::*;
#(
    parameter int DATA_W       = 10,
    parameter int MAX_POWER    = 3,
    parameter int CLEAR_CYCLES = 2,
    parameter int DROP_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              strobe_i,
    input  logic [1:0]        sel_i,
    input  logic [DATA_W-1:0] filt_data_i,
    input  logic              filt_strobe_i,
    output logic              filt_strobe_o,
    output logic              filt_clear_o,
    output logic [1:0]        sel_o,
    output logic [DATA_W-1:0] data_o,
    output logic              strobe_o,
    output logic              ready_o,
    output logic              err_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

    localparam logic [3:0] CLR_LAST = 4'(CLEAR_CYCLES - 1);

    state_t               state, state_nx;
    logic [3:0]           clear_cnt, clear_cnt_nx;
    logic [MAX_POWER-1:0] warm_cnt, warm_cnt_nx, win_last;
    logic [1:0]           sel_nx;
    logic [DATA_W-1:0]    data_nx;
    logic                 strobe_nx, pass, sel_ok;

    assign sel_ok   = (sel_i != SEL_INVALID) && (int'(sel_i) < MAX_POWER);
    assign win_last = MAX_POWER'(win_len(sel_o) - 1);

    always_comb begin
        state_nx     = state;
        clear_cnt_nx = clear_cnt;
        warm_cnt_nx  = warm_cnt;
        sel_nx       = sel_o;
        data_nx      = data_o;
        strobe_nx    = 1'b0;
        pass         = 1'b0;
        case (state)
            CLEAR: begin
                if (!sel_ok) begin
                    state_nx = HOLD;
                    data_nx  = '0;
                end else if (sel_i != sel_o) begin
                    sel_nx       = sel_i;
                    clear_cnt_nx = '0;
                end else if (clear_cnt == CLR_LAST) begin
                    state_nx     = WARMUP;
                    clear_cnt_nx = '0;
                    warm_cnt_nx  = '0;
                end else begin
                    clear_cnt_nx = clear_cnt + 4'd1;
                end
            end
            WARMUP, RUN: begin
                // Any select request differing from the active one pre-empts this
                // cycle's sample and filter output.
                if (!sel_ok) begin
                    state_nx = HOLD;
                    data_nx  = '0;
                end else if (sel_i != sel_o) begin
                    state_nx     = CLEAR;
                    sel_nx       = sel_i;
                    clear_cnt_nx = '0;
                end else begin
                    pass = 1'b1;
                    if (filt_strobe_i) begin
                        if (state == RUN || warm_cnt == win_last) begin
                            state_nx  = RUN;
                            data_nx   = filt_data_i;
                            strobe_nx = 1'b1;
                        end else begin
                            warm_cnt_nx = warm_cnt + 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                data_nx = '0;
                if (sel_ok) begin
                    state_nx     = CLEAR;
                    sel_nx       = sel_i;
                    clear_cnt_nx = '0;
                end
            end
            default: state_nx = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clear_cnt <= '0;
            warm_cnt  <= '0;
            sel_o     <= SEL_W2;
            data_o    <= '0;
            strobe_o  <= 1'b0;
        end else begin
            state     <= state_nx;
            clear_cnt <= clear_cnt_nx;
            warm_cnt  <= warm_cnt_nx;
            sel_o     <= sel_nx;
            data_o    <= data_nx;
            strobe_o  <= strobe_nx;
        end
    end

    assign filt_strobe_o = pass & strobe_i;
    assign filt_clear_o  = (state == CLEAR) || (state == HOLD);
    assign ready_o       = (state == RUN);
    assign err_o         = (state == HOLD);

    sat_counter #(.W(DROP_W)) u_drop (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (strobe_i & ~pass),
        .cnt   (drop_cnt_o)
    );

endmodule

// File: tb/tb_moving_average_ctrl.sv
// Scoreboard bench for moving_average_ctrl; a second instance with a 3-bit drop
// counter shares the stimulus to exercise saturation.
module tb_moving_average_ctrl;
    import moving_average_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       strobe_i = 1'b0;
    logic [1:0] sel_i = 2'b00;
    logic [9:0] filt_data_i = '0;
    logic       filt_strobe_i = 1'b0;
    logic       filt_strobe_o, filt_clear_o, strobe_o, ready_o, err_o;
    logic [1:0] sel_o;
    logic [9:0] data_o;
    logic [7:0] drop_cnt_o;

    logic       d2_fso, d2_fco, d2_so, d2_ro, d2_eo;
    logic [1:0] d2_sel;
    logic [9:0] d2_data;
    logic [2:0] d2_drop;

    typedef struct {
        logic [9:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic last_fso;

    moving_average_ctrl dut (
        .clk(clk), .rst_n(rst_n), .strobe_i(strobe_i), .sel_i(sel_i),
        .filt_data_i(filt_data_i), .filt_strobe_i(filt_strobe_i),
        .filt_strobe_o(filt_strobe_o), .filt_clear_o(filt_clear_o), .sel_o(sel_o),
        .data_o(data_o), .strobe_o(strobe_o), .ready_o(ready_o), .err_o(err_o),
        .drop_cnt_o(drop_cnt_o)
    );

    moving_average_ctrl #(.DROP_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .strobe_i(strobe_i), .sel_i(sel_i),
        .filt_data_i(filt_data_i), .filt_strobe_i(filt_strobe_i),
        .filt_strobe_o(d2_fso), .filt_clear_o(d2_fco), .sel_o(d2_sel),
        .data_o(d2_data), .strobe_o(d2_so), .ready_o(d2_ro), .err_o(d2_eo),
        .drop_cnt_o(d2_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Output side of the scoreboard: every strobe_o must match the oldest forward.
    always @(negedge clk) begin
        if (strobe_o) begin
            if (sb.size() == 0) begin
                chk("spurious_strobe", strobe_o, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_data", data_o, e.data);
                chk("sb_cycle", cyc, e.cyc);
            end
        end
    end

    // Apply inputs for one cycle starting at a negedge; return at the next negedge.
    task automatic step(input logic s, input logic [1:0] sel, input logic fs,
                        input logic [9:0] fd, input logic fwd);
        strobe_i = s; sel_i = sel; filt_strobe_i = fs; filt_data_i = fd;
        #1;
        last_fso = filt_strobe_o;
        if (fs && fwd) sb.push_back(exp_t'{fd, cyc + 1});
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [1:0] sel);
        repeat (n) step(1'b0, sel, 1'b0, 10'h0, 1'b0);
    endtask

    // Filter pulses through warm-up: n_sup suppressed, then one forwarded.
    task automatic warm(input int n_sup, input logic [1:0] sel, input int gap,
                        input logic [9:0] base);
        for (int k = 0; k <= n_sup; k++) begin
            step(1'b0, sel, 1'b1, base + 10'(k), k == n_sup);
            chk("warm_ready", ready_o, (k == n_sup) ? 1 : 0);
            idle(gap, sel);
        end
    endtask

    task automatic chk_clear_seq(input logic [1:0] sel);
        idle(1, sel);
        chk("clr_hold", filt_clear_o, 1);
        idle(1, sel);
        chk("clr_done", filt_clear_o, 0);
        chk("clr_ready", ready_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, with a live strobe that must not pass or count.
        strobe_i = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("rst_fso", filt_strobe_o, 0);
        chk("rst_sel", sel_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_strobe", strobe_o, 0);
        chk("rst_clear", filt_clear_o, 1);
        chk("rst_ready", ready_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_drop", drop_cnt_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Bring-up with WIN=2.
        idle(1, SEL_W2);
        chk("t1_clear_c1", filt_clear_o, 1);
        idle(1, SEL_W2);
        chk("t1_clear_off", filt_clear_o, 0);
        step(1'b1, SEL_W2, 1'b0, 10'h0, 1'b0);
        chk("t1_passthru", last_fso, 1);
        chk("t1_nodrop", drop_cnt_o, 0);
        warm(1, SEL_W2, 1, 10'h02A);
        chk("t1_data", data_o, 10'h02B);
        step(1'b0, SEL_W2, 1'b1, 10'h3FF, 1'b1);
        step(1'b0, SEL_W2, 1'b1, 10'h155, 1'b1);
        idle(2, SEL_W2);
        chk("t1_hold_data", data_o, 10'h155);

        // Switch to WIN=8 from RUN.
        idle(1, SEL_W8);
        chk("t2_sel", sel_o, SEL_W8);
        chk("t2_clear", filt_clear_o, 1);
        chk("t2_ready", ready_o, 0);
        chk_clear_seq(SEL_W8);
        warm(7, SEL_W8, 3, 10'h100);

        // Change coinciding with strobe_i and filt_strobe_i.
        step(1'b1, SEL_W4, 1'b1, 10'h099, 1'b0);
        chk("t3_fso", last_fso, 0);
        chk("t3_drop", drop_cnt_o, 1);
        chk("t3_sel", sel_o, SEL_W4);
        idle(1, SEL_W4);
        chk("t3_strobe", strobe_o, 0);
        chk("t3_clear", filt_clear_o, 1);
        idle(1, SEL_W4);
        warm(3, SEL_W4, 1, 10'h2C0);

        // Invalid select for 5 cycles with strobes, then back to W4.
        for (int k = 0; k < 5; k++) begin
            step(1'b1, SEL_INVALID, k[0], 10'h3AA, 1'b0);
            chk("t4_fso", last_fso, 0);
            chk("t4_err", err_o, 1);
            chk("t4_data", data_o, 0);
            chk("t4_clear", filt_clear_o, 1);
        end
        chk("t4_drop", drop_cnt_o, 6);
        chk("t4_drop2", d2_drop, 6);
        idle(1, SEL_W4);
        chk("t4_err_off", err_o, 0);
        chk("t4_reclear", filt_clear_o, 1);
        chk("t4_sel", sel_o, SEL_W4);
        chk_clear_seq(SEL_W4);
        warm(3, SEL_W4, 2, 10'h011);

        // Ten more drops: 8-bit counter keeps counting, 3-bit one saturates.
        repeat (10) step(1'b1, SEL_INVALID, 1'b0, 10'h0, 1'b0);
        chk("t5_drop", drop_cnt_o, 16);
        chk("t5_drop2_sat", d2_drop, 7);
        idle(1, SEL_W4);
        idle(2, SEL_W4);
        warm(3, SEL_W4, 1, 10'h1E0);
        chk("t5_run_sel", sel_o, SEL_W4);

        // One-cycle reset in the middle of RUN.
        rst_n = 1'b0;
        step(1'b1, SEL_W4, 1'b1, 10'h077, 1'b0);
        rst_n = 1'b1;
        chk("t6_sel", sel_o, SEL_W2);
        chk("t6_data", data_o, 0);
        chk("t6_strobe", strobe_o, 0);
        chk("t6_clear", filt_clear_o, 1);
        chk("t6_ready", ready_o, 0);
        chk("t6_err", err_o, 0);
        chk("t6_drop", drop_cnt_o, 0);
        chk("t6_drop2", d2_drop, 0);
        chk_clear_seq(SEL_W2);
        warm(1, SEL_W2, 1, 10'h0F0);
        idle(2, SEL_W2);

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/moving_average_ctrl.md
Name: moving_average_ctrl

Overview:
Sequencing controller between the pin-level front end and the moving-average filter bank. It applies window-length changes only at safe points and flushes the filter datapath on every change. It gates the filter's partial-window (warm-up) outputs so that only full-window averages reach the output. It also counts input samples dropped while a reconfiguration is in progress.

Parameters:
DATA_W, 10, width of filter data path
MAX_POWER, 3, largest supported window exponent (window = 2^power); select codes above MAX_POWER-1 are invalid
CLEAR_CYCLES, 2, cycles filt_clear_o is held high per reconfiguration (1..15)
DROP_W, 8, width of dropped-sample counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
strobe_i  in  1  input sample strobe from pins
sel_i  in  2  requested window select (00=2, 01=4, 10=8, 11=invalid)
filt_data_i  in  DATA_W  output data of selected filter
filt_strobe_i  in  1  output strobe of selected filter
filt_strobe_o  out  1  gated sample strobe to filter bank
filt_clear_o  out  1  synchronous clear to filter accumulators/delay lines
sel_o  out  2  applied (active) window select to filter mux
data_o  out  DATA_W  averaged output
strobe_o  out  1  output strobe, one cycle per valid average
ready_o  out  1  high only in RUN
err_o  out  1  high while invalid select requested
drop_cnt_o  out  DROP_W  samples dropped since reset, saturating

Behaviour:
- Reset (rst_n low at posedge): state=CLEAR, clear_cnt=0, sel_o=00, data_o=0, strobe_o=0, filt_strobe_o=0, filt_clear_o=1, ready_o=0, err_o=0, drop_cnt_o=0, warm_cnt=0.
- Reset asserted mid-operation overrides everything in that cycle; no partial state survives.
- States: CLEAR, WARMUP, RUN, HOLD.
- CLEAR:
  - filt_clear_o=1; clear_cnt increments each cycle.
  - After CLEAR_CYCLES cycles, go to WARMUP with warm_cnt=0.
  - Every strobe_i is dropped: filt_strobe_o=0, drop_cnt increments.
- WARMUP:
  - filt_strobe_o = strobe_i, combinational pass-through, zero latency.
  - Each filt_strobe_i increments warm_cnt; strobe_o stays 0.
  - When warm_cnt reaches WIN-1 (WIN = 2^(sel_o+1)), the next filt_strobe_i is forwarded and the state becomes RUN.
- RUN:
  - filt_strobe_o = strobe_i.
  - On filt_strobe_i: data_o <= filt_data_i and strobe_o <= 1 one cycle later. strobe_o is otherwise 0.
  - data_o holds its last value between strobes.
- Select change detection runs every cycle in WARMUP and RUN:
  - sel_i != sel_o and sel_i valid: sel_o <= sel_i next cycle, state -> CLEAR, clear_cnt=0.
  - sel_i invalid (11): state -> HOLD.
- A simultaneous strobe_i in the change-detect cycle is dropped and counted. A simultaneous filt_strobe_i in that cycle is discarded; strobe_o stays 0.
- HOLD:
  - err_o=1, data_o=0, strobe_o=0, filt_strobe_o=0, filt_clear_o=1; strobe_i is dropped and counted.
  - When sel_i becomes valid, sel_o <= sel_i and state -> CLEAR (full clear even if sel_i equals the old sel_o).
- A change of sel_i during CLEAR restarts CLEAR with the new sel_o (clear_cnt=0).
- drop_cnt_o saturates at all-ones; it never wraps.
- ready_o = (state==RUN), registered with state.
- Widths: warm_cnt is MAX_POWER bits wide; WIN-1 is compared at MAX_POWER bits; no arithmetic on data (pass-through).

Decomposition:
- Shared package moving_average_pkg holds:
  - state enum (CLEAR, WARMUP, RUN, HOLD)
  - select code constants SEL_W2=00, SEL_W4=01, SEL_W8=10, SEL_INVALID=11
  - window-length function win_len(sel) = 2^(sel+1)
- One sub-module, sat_counter (width-parameterised saturating increment), is used for drop_cnt. Everything else stays flat in moving_average_ctrl.

Test Plan:
- Reset then sel_i=00 held, constant CLEAR_CYCLES=2 → filt_clear_o high for cycles 0-1 after rst_n rise, ready_o low until 2nd filt_strobe_i; first strobe_o one cycle after 2nd filt_strobe_i, data_o=filt_data_i of that strobe.
- sel_i=10 in RUN, filt_strobe_i every 4 cycles → sel_o=10 next cycle, 2 clear cycles, first 7 filt_strobe_i suppressed, 8th forwarded; ready_o rises with 8th.
- sel_i change coinciding with strobe_i and filt_strobe_i → drop_cnt_o +1, no strobe_o that cycle or next, filt_strobe_o=0.
- sel_i=11 for 5 cycles with strobe_i every cycle, then 01 → err_o=1 and data_o=0 during HOLD, drop_cnt_o=5, then CLEAR and WARMUP with WIN=4.
- DROP_W=3, 10 strobes during HOLD → drop_cnt_o stops at 7.
- rst_n low for 1 cycle mid-RUN with sel_o=01 → all outputs at reset values next cycle, sel_o=00, CLEAR restarts.
